// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide sequencer driving shared unsigned Mul and Div units
// Optional macro: MULDIV_DIVZERO_BYPASS_EN (divide-by-zero answered locally, Div unit skipped)
module muldiv_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        cancel,
    output logic        stall_out,
    output logic        busy,
    output logic        mul_valid,
    output logic        div_valid,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        mul_done,
    input  logic        div_done,
    input  logic [63:0] mul_c,
    input  logic [63:0] div_c,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_data,
    output logic [31:0] lo_data,
    output logic        gpr_valid,
    output logic [31:0] gpr_data
);

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_BUSY,
        S_DIV_BUSY,
        S_RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  op_q;
    logic        sign_a_q;
    logic        sign_b_q;
    logic [31:0] mag_a_q;
    logic [31:0] mag_b_q;
    logic [63:0] res_q;

    logic        req_legal;
    logic        req_signed;
    logic        req_is_div;
    logic        accept;
    logic        div_zero;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a_d;
    logic [31:0] mag_b_d;
    logic [63:0] mul_fix;
    logic [31:0] div_q_fix;
    logic [31:0] div_r_fix;
    logic        resp_ok;

    assign req_legal  = (req_op <= OP_MUL);
    assign req_signed = (req_op == OP_MULT) || (req_op == OP_DIV) || (req_op == OP_MUL);
    assign req_is_div = (req_op == OP_DIVU) || (req_op == OP_DIV);
    assign accept     = (state_q == S_IDLE) && req_valid && req_legal && !cancel;

    assign neg_a   = req_signed && req_a[31];
    assign neg_b   = req_signed && req_b[31];
    assign mag_a_d = neg_a ? (32'd0 - req_a) : req_a;
    assign mag_b_d = neg_b ? (32'd0 - req_b) : req_b;

`ifdef MULDIV_DIVZERO_BYPASS_EN
    assign div_zero = req_is_div && (req_b == 32'd0);
`else
    assign div_zero = 1'b0;
`endif

    // Units work on magnitudes; signs are reapplied here (remainder follows the dividend).
    assign mul_fix   = (sign_a_q ^ sign_b_q) ? (64'd0 - mul_c) : mul_c;
    assign div_q_fix = (sign_a_q ^ sign_b_q) ? (32'd0 - div_c[31:0]) : div_c[31:0];
    assign div_r_fix = sign_a_q ? (32'd0 - div_c[63:32]) : div_c[63:32];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (div_zero)
                        state_d = S_RESP;
                    else if (req_is_div)
                        state_d = S_DIV_BUSY;
                    else
                        state_d = S_MUL_BUSY;
                end
            end
            S_MUL_BUSY: begin
                if (cancel)
                    state_d = S_IDLE;
                else if (mul_done)
                    state_d = S_RESP;
            end
            S_DIV_BUSY: begin
                if (cancel)
                    state_d = S_IDLE;
                else if (div_done)
                    state_d = S_RESP;
            end
            // The instruction is still presented during RESP, so never re-accept here.
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
            res_q    <= 64'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= req_op;
                sign_a_q <= neg_a;
                sign_b_q <= neg_b;
                mag_a_q  <= mag_a_d;
                mag_b_q  <= mag_b_d;
                if (div_zero)
                    res_q <= {req_a, 32'hFFFF_FFFF};
            end
            if ((state_q == S_MUL_BUSY) && mul_done && !cancel)
                res_q <= mul_fix;
            if ((state_q == S_DIV_BUSY) && div_done && !cancel)
                res_q <= {div_r_fix, div_q_fix};
        end
    end

    assign stall_out = accept || (state_q == S_MUL_BUSY) || (state_q == S_DIV_BUSY);
    assign busy      = (state_q != S_IDLE);
    assign mul_valid = (state_q == S_MUL_BUSY) && !cancel;
    assign div_valid = (state_q == S_DIV_BUSY) && !cancel;
    assign op_a      = mag_a_q;
    assign op_b      = mag_b_q;

    assign resp_ok   = (state_q == S_RESP) && !cancel;
    assign hi_we     = resp_ok && (op_q != OP_MUL);
    assign lo_we     = resp_ok && (op_q != OP_MUL);
    assign gpr_valid = resp_ok && (op_q == OP_MUL);
    assign hi_data   = res_q[63:32];
    assign lo_data   = res_q[31:0];
    assign gpr_data  = res_q[31:0];

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed scoreboard bench for muldiv_ctrl with behavioural Mul/Div units
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        cancel;
    logic        stall_out;
    logic        busy;
    logic        mul_valid;
    logic        div_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mul_done;
    logic        div_done;
    logic [63:0] mul_c;
    logic [63:0] div_c;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_data;
    logic [31:0] lo_data;
    logic        gpr_valid;
    logic [31:0] gpr_data;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        gpr;
        logic [63:0] res;
    } exp_t;
    exp_t sb[$];

    int          mul_lat = 4;
    int          div_lat = 4;
    int          mul_cnt = 0;
    int          div_cnt = 0;
    int          div_cycles = 0;
    logic        mul_done_m = 1'b0;
    logic        mul_done_x = 1'b0;
    logic [31:0] cap_a = 32'd0;
    logic [31:0] cap_b = 32'd0;

    assign mul_done = mul_done_m | mul_done_x;

    muldiv_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .cancel    (cancel),
        .stall_out (stall_out),
        .busy      (busy),
        .mul_valid (mul_valid),
        .div_valid (div_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .mul_done  (mul_done),
        .div_done  (div_done),
        .mul_c     (mul_c),
        .div_c     (div_c),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .hi_data   (hi_data),
        .lo_data   (lo_data),
        .gpr_valid (gpr_valid),
        .gpr_data  (gpr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] pa;
        logic signed [63:0] pb;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic [31:0]        q;
        logic [31:0]        r;
        pa  = {{32{a[31]}}, a};
        pb  = {{32{b[31]}}, b};
        sa  = a;
        sbv = b;
        case (op)
            3'd0: model = {32'd0, a} * {32'd0, b};
            3'd1, 3'd4: model = pa * pb;
            3'd2: model = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 32'd0) begin
                    model = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    model = {r, q};
                end
            end
        endcase
    endfunction

    // Behavioural units: done on the lat-th cycle of a held valid strobe.
    always @(negedge clk) begin
        if (mul_valid) begin
            mul_cnt++;
            mul_c = {32'd0, op_a} * {32'd0, op_b};
            mul_done_m = (mul_cnt >= mul_lat);
        end else begin
            mul_cnt = 0;
            mul_done_m = 1'b0;
        end
        if (div_valid) begin
            div_cnt++;
            div_cycles++;
            cap_a = op_a;
            cap_b = op_b;
            div_c = (op_b == 32'd0) ? {op_a, 32'hFFFF_FFFF} : {op_a % op_b, op_a / op_b};
            div_done = (div_cnt >= div_lat);
        end else begin
            div_cnt = 0;
            div_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (resetn && (hi_we || lo_we || gpr_valid)) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {61'd0, hi_we, lo_we, gpr_valid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.gpr) begin
                    chk("gpr_strobe", {61'd0, hi_we, lo_we, gpr_valid}, 64'd1);
                    chk("gpr_data", {32'd0, gpr_data}, {32'd0, e.res[31:0]});
                end else begin
                    chk("hilo_strobe", {61'd0, hi_we, lo_we, gpr_valid}, 64'd6);
                    chk("hi_data", {32'd0, hi_data}, {32'd0, e.res[63:32]});
                    chk("lo_data", {32'd0, lo_data}, {32'd0, e.res[31:0]});
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int exp_stall, input string tag);
        exp_t e;
        int   n;
        logic done;
        e.gpr = (op == 3'd4);
        e.res = model(op, a, b);
        sb.push_back(e);
        mul_lat = lat;
        div_lat = lat;
        step();
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (!stall_out) begin
                done = 1'b1;
                break;
            end
            n++;
            step();
        end
        chk({tag, "_timeout"}, {63'd0, done}, 64'd1);
        chk({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        req_valid = 1'b0;
        req_op = 3'd0;
        req_a = 32'd0;
        req_b = 32'd0;
        cancel = 1'b0;
        mul_c = 64'd0;
        div_c = 64'd0;
        div_done = 1'b0;
        repeat (2) step();
        #1;
        chk("rst_strobes", {57'd0, busy, stall_out, mul_valid, div_valid, hi_we, lo_we, gpr_valid}, 64'd0);
        chk("rst_op", {op_a, op_b}, 64'd0);
        chk("rst_hilo", {hi_data, lo_data}, 64'd0);
        chk("rst_gpr", {32'd0, gpr_data}, 64'd0);
        resetn = 1'b1;

        run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 4, 5, "mult_neg");
        div_cycles = 0;
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 3, 4, "div_neg");
        chk("div_op_a", {32'd0, cap_a}, 64'd7);
        chk("div_op_b", {32'd0, cap_b}, 64'd2);
        chk("div_valid_cycles", 64'(div_cycles), 64'd3);
        run_op(3'd4, 32'h0001_0000, 32'h0001_0000, 2, 3, "mul_wrap");
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 2, "multu_max");
        run_op(3'd3, 32'd7, 32'hFFFF_FFFE, 5, 6, "div_negb");
        run_op(3'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 2, 3, "div_negab");
        run_op(3'd2, 32'hDEAD_BEEF, 32'd1000, 6, 7, "divu");
        run_op(3'd4, 32'hFFFF_FFFB, 32'd6, 3, 4, "mul_neg");
        for (int i = 0; i < 3; i++)
            run_op(3'd1, $urandom, $urandom, 1 + (i % 3), 2 + (i % 3), "mult_rand");

        step();
        req_valid = 1'b1;
        req_op = 3'd5;
        req_a = 32'd3;
        req_b = 32'd4;
        #1;
        chk("reserved_stall", {63'd0, stall_out}, 64'd0);
        step();
        #1;
        chk("reserved_busy", {63'd0, busy}, 64'd0);
        req_valid = 1'b0;

        mul_lat = 10;
        step();
        req_valid = 1'b1;
        req_op = 3'd0;
        req_a = 32'd5;
        req_b = 32'd6;
        step();
        step();
        cancel = 1'b1;
        req_valid = 1'b0;
        step();
        cancel = 1'b0;
        #1;
        chk("cancel_idle", {62'd0, busy, mul_valid}, 64'd0);
        mul_done_x = 1'b1;
        step();
        mul_done_x = 1'b0;
        #1;
        chk("late_done_ignored", {62'd0, busy, stall_out}, 64'd0);
        run_op(3'd0, 32'd12, 32'd13, 3, 4, "after_cancel");

        div_cycles = 0;
`ifdef MULDIV_DIVZERO_BYPASS_EN
        run_op(3'd2, 32'd9, 32'd0, 4, 1, "divz");
        chk("divz_no_div_valid", 64'(div_cycles), 64'd0);
`else
        run_op(3'd2, 32'd9, 32'd0, 4, 5, "divz");
        chk("divz_dispatched", 64'(div_cycles), 64'd4);
`endif

        div_lat = 10;
        step();
        req_valid = 1'b1;
        req_op = 3'd3;
        req_a = 32'd100;
        req_b = 32'd7;
        step();
        step();
        step();
        resetn = 1'b0;
        req_valid = 1'b0;
        step();
        #1;
        chk("midreset_strobes", {57'd0, busy, stall_out, mul_valid, div_valid, hi_we, lo_we, gpr_valid}, 64'd0);
        chk("midreset_data", {op_a, op_b}, 64'd0);
        chk("midreset_hilo", {hi_data, lo_data}, 64'd0);
        resetn = 1'b1;
        repeat (15) step();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
